uart_rx: RTL and testbench

- UART receiver for the host-to-SDRAM write path; the opposite end of the board's UART transmit link.
- Deserialises 8N1 frames from rs232_rx and pushes each received byte into the write FIFO (WFIFO) that feeds the SDRAM write controller.
- Same baud scheme and data framing as the transmit side: LSB first, 1 start bit, 1 stop bit, no parity.

---
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// WFIFO-side port bundle of the UART receiver: write strobe/data, full flag and error pulses.
interface uart_rx_if;
    logic       wfifo_full;
    logic       wfifo_wr_en;
    logic [7:0] wfifo_wr_data;
    logic       rx_overflow;
    logic       rx_frame_err;

    modport master (
        input  wfifo_full,
        output wfifo_wr_en,
        output wfifo_wr_data,
        output rx_overflow,
        output rx_frame_err
    );

    modport slave (
        output wfifo_full,
        input  wfifo_wr_en,
        input  wfifo_wr_data,
        input  rx_overflow,
        input  rx_frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver feeding the SDRAM write FIFO; stop-bit checking with BREAK_WAIT
// recovery is enabled by defining UART_RX_FRAME_CHK_EN.
module uart_rx #(
    parameter int BAUD_END = 5207,
    parameter int BAUD_M   = BAUD_END / 2 - 1
) (
    input  logic sclk,
    input  logic s_rst_n,
    input  logic rs232_rx,
    uart_rx_if.master wf
);
    localparam logic [12:0] BAUD_END_C = 13'(BAUD_END);
    localparam logic [12:0] BAUD_M_C   = 13'(BAUD_M);

`ifdef UART_RX_FRAME_CHK_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state_q, state_d;
    logic        rx_r1_q, rx_r2_q, rx_r3_q;
    logic [12:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        ovf_q, ovf_d;
    logic        fall_edge, baud_mid, baud_end, write_go;
`ifdef UART_RX_FRAME_CHK_EN
    logic        ferr_q, ferr_d;
`endif

    assign fall_edge = rx_r3_q & ~rx_r2_q;
    assign baud_mid  = (baud_cnt_q == BAUD_M_C);
    assign baud_end  = (baud_cnt_q == BAUD_END_C);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_end ? 13'd0 : baud_cnt_q + 13'd1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        ovf_d      = 1'b0;
        write_go   = 1'b0;
`ifdef UART_RX_FRAME_CHK_EN
        ferr_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                baud_cnt_d = 13'd0;
                bit_cnt_d  = 3'd0;
                if (fall_edge) state_d = START;
            end
            START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (baud_mid && rx_r2_q) begin
                    state_d = IDLE;
                end else if (baud_end) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (baud_mid) shift_d[bit_cnt_q] = rx_r2_q;
                if (baud_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Leave at mid-stop so a start bit right after the stop bit is not missed.
                if (baud_mid) begin
`ifdef UART_RX_FRAME_CHK_EN
                    if (!rx_r2_q) begin
                        ferr_d  = 1'b1;
                        state_d = BREAK_WAIT;
                    end else begin
                        write_go = 1'b1;
                        state_d  = IDLE;
                    end
`else
                    write_go = 1'b1;
                    state_d  = IDLE;
`endif
                end
            end
`ifdef UART_RX_FRAME_CHK_EN
            BREAK_WAIT: begin
                if (!rx_r2_q)      baud_cnt_d = 13'd0;
                else if (baud_end) state_d    = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        if (write_go) begin
            if (wf.wfifo_full) begin
                ovf_d = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_data_d = shift_d;
            end
        end

        if (state_d != state_q) baud_cnt_d = 13'd0;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            rx_r1_q    <= 1'b1;
            rx_r2_q    <= 1'b1;
            rx_r3_q    <= 1'b1;
            state_q    <= IDLE;
            baud_cnt_q <= 13'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= 8'd0;
            ovf_q      <= 1'b0;
        end else begin
            rx_r1_q    <= rs232_rx;
            rx_r2_q    <= rx_r1_q;
            rx_r3_q    <= rx_r2_q;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef UART_RX_FRAME_CHK_EN
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) ferr_q <= 1'b0;
        else          ferr_q <= ferr_d;
    end
    assign wf.rx_frame_err = ferr_q;
`else
    assign wf.rx_frame_err = 1'b0;
`endif

    assign wf.wfifo_wr_en   = wr_en_q;
    assign wf.wfifo_wr_data = wr_data_q;
    assign wf.rx_overflow   = ovf_q;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frame-level reference model, directed cases then random frames.
module tb_uart_rx;
    localparam int BAUD_END = 28;
    localparam int BIT      = BAUD_END + 1;
    localparam int LAT      = 278;
`ifdef UART_RX_FRAME_CHK_EN
    localparam bit FCHK = 1'b1;
`else
    localparam bit FCHK = 1'b0;
`endif

    typedef enum int {EV_WR, EV_OVF, EV_FERR} ev_t;
    typedef struct {
        ev_t        kind;
        logic [7:0] data;
        longint     start;
    } exp_t;

    logic   sclk     = 1'b0;
    logic   s_rst_n  = 1'b0;
    logic   rs232_rx = 1'b1;
    longint cyc      = 0;
    int     errors   = 0;
    int     checks   = 0;
    logic [7:0] last_wr = 8'h00;
    logic   prev_wr  = 1'b0;
    exp_t   sb[$];

    uart_rx_if wf_if ();

    uart_rx #(.BAUD_END(BAUD_END)) dut (
        .sclk     (sclk),
        .s_rst_n  (s_rst_n),
        .rs232_rx (rs232_rx),
        .wf       (wf_if.master)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    // Reference model: what one complete frame must produce, from the frame rules alone.
    function automatic exp_t model(logic [7:0] d, bit stop_ok, bit full, longint st);
        exp_t e;
        e.data  = d;
        e.start = st;
        if (!stop_ok && FCHK) e.kind = EV_FERR;
        else if (full)        e.kind = EV_OVF;
        else                  e.kind = EV_WR;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic idle(int n);
        rs232_rx = 1'b1;
        wait_cyc(n);
    endtask

    task automatic send_frame(logic [7:0] d, bit stop_ok, bit full);
        wf_if.wfifo_full = full;
        sb.push_back(model(d, stop_ok, full, cyc));
        $display("tx frame data=%02h stop_ok=%0d full=%0d start=%0d", d, stop_ok, full, cyc);
        rs232_rx = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = d[i];
            wait_cyc(BIT);
        end
        rs232_rx = stop_ok;
        wait_cyc(BIT);
        rs232_rx = 1'b1;
    endtask

    task automatic check_event(ev_t kind, logic [7:0] data);
        exp_t   e;
        longint lat;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d data=%02h expected none", kind, data);
            return;
        end
        e = sb.pop_front();
        lat = cyc - e.start;
        $display("rx event kind=%0d data=%02h latency=%0d", kind, data, lat);
        if (e.kind != kind) begin
            errors++;
            $display("FAIL event_kind: got %0d expected %0d", kind, e.kind);
        end else if (kind == EV_WR && data !== e.data) begin
            errors++;
            $display("FAIL wr_data: got %02h expected %02h", data, e.data);
        end else if (kind != EV_WR && data !== last_wr) begin
            errors++;
            $display("FAIL wr_data_hold: got %02h expected %02h", data, last_wr);
        end
        checks++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
            errors++;
            $display("FAIL latency: got %0d expected %0d+-1", lat, LAT);
        end
        if (kind == EV_WR) last_wr = data;
    endtask

    // Monitor: every output pulse is matched against the scoreboard head.
    always @(negedge sclk) begin
        if (s_rst_n) begin
            if (int'(wf_if.wfifo_wr_en) + int'(wf_if.rx_overflow) + int'(wf_if.rx_frame_err) > 1) begin
                checks++;
                errors++;
                $display("FAIL simultaneous_pulses: got wr=%0b ovf=%0b ferr=%0b expected at most one",
                         wf_if.wfifo_wr_en, wf_if.rx_overflow, wf_if.rx_frame_err);
            end
            if (wf_if.wfifo_wr_en) begin
                checks++;
                if (prev_wr) begin
                    errors++;
                    $display("FAIL back_to_back_write: got 2 consecutive strobes expected 1");
                end
                check_event(EV_WR, wf_if.wfifo_wr_data);
            end
            if (wf_if.rx_overflow)  check_event(EV_OVF, wf_if.wfifo_wr_data);
            if (wf_if.rx_frame_err) check_event(EV_FERR, wf_if.wfifo_wr_data);
            prev_wr = wf_if.wfifo_wr_en;
        end else begin
            prev_wr = 1'b0;
        end
    end

    initial begin
        repeat (60000) @(posedge sclk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit prev_ok;
        wf_if.wfifo_full = 1'b0;
        wait_cyc(3);
        chk("rst_wr_en", 32'(wf_if.wfifo_wr_en), 32'd0);
        chk("rst_wr_data", 32'(wf_if.wfifo_wr_data), 32'd0);
        chk("rst_overflow", 32'(wf_if.rx_overflow), 32'd0);
        chk("rst_frame_err", 32'(wf_if.rx_frame_err), 32'd0);
        s_rst_n = 1'b1;
        idle(5);

        send_frame(8'hA5, 1'b1, 1'b0);
        idle(20);

        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(20);

        $display("tx glitch 5 cycles");
        rs232_rx = 1'b0;
        wait_cyc(5);
        idle(60);
        send_frame(8'h55, 1'b1, 1'b0);
        idle(20);

        send_frame(8'h81, 1'b1, 1'b1);
        idle(10);
        send_frame(8'h12, 1'b1, 1'b0);
        idle(20);

        // Reset in the middle of bit 4 of 0x9F: nothing may be written for it.
        $display("tx aborted frame 9f with reset in bit 4");
        rs232_rx = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 4; i++) begin
            rs232_rx = 1'(8'h9F >> i);
            wait_cyc(BIT);
        end
        rs232_rx = 1'b1;
        wait_cyc(10);
        s_rst_n = 1'b0;
        #1;
        chk("midrst_wr_data", 32'(wf_if.wfifo_wr_data), 32'd0);
        chk("midrst_wr_en", 32'(wf_if.wfifo_wr_en), 32'd0);
        last_wr = 8'h00;
        wait_cyc(3);
        s_rst_n = 1'b1;
        idle(10);
        send_frame(8'h9F, 1'b1, 1'b0);
        idle(20);

        send_frame(8'h6B, 1'b0, 1'b0);
        idle(40);
        send_frame(8'h6B, 1'b1, 1'b0);
        idle(20);

        prev_ok = 1'b1;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            bit ok, full;
            d    = 8'($urandom);
            ok   = ($urandom_range(0, 4) != 0);
            full = ($urandom_range(0, 3) == 0);
            if (!prev_ok)                      idle(40 + $urandom_range(0, 10));
            else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 30));
            send_frame(d, ok, full);
            prev_ok = ok;
        end
        idle(60);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
